// File: rtl/bus_hold_arbiter.sv
// bus_hold_arbiter: shares the 8088 local bus between the CPU and NREQ
// external masters. Raises hold, waits for hlda, then hands the bus to one
// requester at a time in round-robin order with a bounded tenure and a
// one-cycle turnaround between owners. Every output is a flop.
module bus_hold_arbiter #(
  parameter int NREQ       = 4,
  parameter int IDW        = 2,
  parameter int MAX_TENURE = 16,
  parameter int CW         = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            hlda,
  output logic            hold,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  owner,
  output logic            busy,
  output logic            preempt,
  output logic            err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HREQ  = 3'd1,
    GRANT = 3'd2,
    TURN  = 3'd3,
    DROP  = 3'd4
  } state_t;

  localparam logic [CW-1:0]   TEN_LAST = CW'(MAX_TENURE - 1);
  localparam logic [NREQ-1:0] ONE      = NREQ'(1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IDW-1:0]  ptr, ptr_n;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  owner_n;
  logic [NREQ-1:0] gnt_n;
  logic            hold_n, preempt_n, err_n;
  logic            any_req, do_grant;

  // Round-robin search: first set request strictly after p, wrapping.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDW-1:0]  p);
    logic [IDW-1:0] w;
    logic           found;
    int             idx;
    w     = p;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(p) + i) % NREQ;
      if (!found && r[idx]) begin
        w     = IDW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign any_req = |req;
  assign win     = rr_pick(req, ptr);

  // Next-state and next-output decode; grant load is shared by HREQ and TURN.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ptr_n     = ptr;
    owner_n   = owner;
    hold_n    = hold;
    gnt_n     = '0;
    preempt_n = 1'b0;
    err_n     = 1'b0;
    do_grant  = 1'b0;
    unique case (state)
      IDLE: begin
        hold_n = 1'b0;
        if (any_req) begin
          state_n = HREQ;
          hold_n  = 1'b1;
        end
      end
      HREQ: begin
        hold_n = 1'b1;
        if (!any_req) begin
          state_n = DROP;
          hold_n  = 1'b0;
        end else if (hlda) begin
          do_grant = 1'b1;
        end
      end
      GRANT: begin
        hold_n = 1'b1;
        // Release beats preempt, preempt beats the hlda error.
        if (!req[owner]) begin
          state_n = TURN;
          cnt_n   = '0;
        end else if (cnt == TEN_LAST && |(req & ~gnt)) begin
          state_n   = TURN;
          cnt_n     = '0;
          preempt_n = 1'b1;
        end else if (!hlda) begin
          state_n = HREQ;
          cnt_n   = '0;
          err_n   = 1'b1;
        end else begin
          gnt_n = gnt;
          // Saturate so a long lone tenure is cut as soon as anyone else asks.
          if (cnt != TEN_LAST) cnt_n = cnt + CW'(1);
        end
      end
      TURN: begin
        hold_n = 1'b1;
        cnt_n  = '0;
        if (any_req && hlda) begin
          do_grant = 1'b1;
        end else if (any_req) begin
          state_n = HREQ;
        end else begin
          state_n = DROP;
          hold_n  = 1'b0;
        end
      end
      DROP: begin
        // Requests are ignored here so the CPU really gets the bus back.
        hold_n = 1'b0;
        if (!hlda) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        hold_n  = 1'b0;
      end
    endcase
    if (do_grant) begin
      state_n = GRANT;
      gnt_n   = ONE << win;
      owner_n = win;
      ptr_n   = win;
      cnt_n   = '0;
    end
  end

  // State, counter, pointer and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= IDW'(NREQ - 1);
      hold    <= 1'b0;
      gnt     <= '0;
      owner   <= '0;
      busy    <= 1'b0;
      preempt <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ptr     <= ptr_n;
      hold    <= hold_n;
      gnt     <= gnt_n;
      owner   <= owner_n;
      busy    <= hold_n | (|gnt_n);
      preempt <= preempt_n;
      err     <= err_n;
    end
  end

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Directed bench for bus_hold_arbiter: a vector table for single-cycle
// steps plus a hand-written round-robin rotation.
module tb_bus_hold_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            rst, hlda;
  logic [NREQ-1:0] req;
  logic            hold, busy, preempt, err;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  owner;

  int errors = 0;
  int checks = 0;

  bus_hold_arbiter #(.NREQ(NREQ), .IDW(IDW), .MAX_TENURE(4), .CW(3)) dut (
    .clk(clk), .rst(rst), .req(req), .hlda(hlda), .hold(hold), .gnt(gnt),
    .owner(owner), .busy(busy), .preempt(preempt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rst;
    logic [NREQ-1:0] req;
    logic            hlda;
    logic            hold;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  owner;
    logic            pre;
    logic            err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic h,
                     input logic eh, input logic [3:0] eg, input int eo,
                     input logic ep, input logic ee, input int n = 1);
    vec_t v;
    v.rst = r; v.req = rq; v.hlda = h; v.hold = eh; v.gnt = eg;
    v.owner = IDW'(eo); v.pre = ep; v.err = ee;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int order[4] = '{0, 1, 3, 0};

  initial begin
    rst = 1'b1; req = '0; hlda = 1'b0;

    // rst req hlda | hold gnt owner preempt err
    add(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    // single request, then a lone owner that is never preempted
    add(0, 4'b0001, 0, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b0001, 0, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b0001, 1, 1, 4'b0001, 0, 0, 0);
    add(0, 4'b0001, 1, 1, 4'b0001, 0, 0, 0, 6);
    add(0, 4'b0000, 1, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    // tenure preempt (pointer now at 0, so master 1 goes first)
    add(0, 4'b0011, 0, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b0011, 1, 1, 4'b0010, 1, 0, 0, 4);
    add(0, 4'b0011, 1, 1, 4'b0000, 1, 1, 0);
    add(0, 4'b0011, 1, 1, 4'b0001, 0, 0, 0, 4);
    add(0, 4'b0011, 1, 1, 4'b0000, 0, 1, 0);
    add(0, 4'b0011, 1, 1, 4'b0010, 1, 0, 0);
    // hlda drops during a grant
    add(0, 4'b0011, 0, 1, 4'b0000, 1, 0, 1);
    add(0, 4'b0011, 0, 1, 4'b0000, 1, 0, 0);
    add(0, 4'b0011, 1, 1, 4'b0001, 0, 0, 0);
    add(0, 4'b0000, 1, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    // abort before ack; DROP ignores a new request until hlda falls
    add(0, 4'b0100, 0, 1, 4'b0000, 0, 0, 0, 2);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0100, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0100, 0, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0100, 0, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b0100, 1, 1, 4'b0100, 2, 0, 0);
    // reset mid-grant, then the pointer restarts at index 0
    add(1, 4'b0100, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 1, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 1, 1, 4'b0001, 0, 0, 0);

    foreach (vq[i]) begin
      rst = vq[i].rst; req = vq[i].req; hlda = vq[i].hlda;
      tick();
      chk("hold",    i, 32'(hold),    32'(vq[i].hold));
      chk("gnt",     i, 32'(gnt),     32'(vq[i].gnt));
      chk("owner",   i, 32'(owner),   32'(vq[i].owner));
      chk("busy",    i, 32'(busy),    32'(vq[i].hold | (|vq[i].gnt)));
      chk("preempt", i, 32'(preempt), 32'(vq[i].pre));
      chk("err",     i, 32'(err),     32'(vq[i].err));
    end

    // Round robin with req=1011: each owner holds 3 cycles, drops, reasserts.
    rst = 1'b1; req = '0; hlda = 1'b1;
    tick();
    rst = 1'b0; req = 4'b1011;
    tick();
    chk("rr_hreq", 0, {31'(gnt), hold}, {31'(0), 1'b1});
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        chk("rr_gnt",   k, 32'(gnt),   32'(4'b0001 << order[k]));
        chk("rr_owner", k, 32'(owner), 32'(order[k]));
        chk("rr_hold",  k, 32'(hold),  32'(1));
      end
      req = 4'b1011 & ~(4'b0001 << order[k]);
      tick();
      chk("rr_turn", k, {31'(gnt), hold}, {31'(0), 1'b1});
      req = 4'b1011;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
